// File: rtl/ltc_pkg.sv
// Shared types and widths for the lattice-to-colour pixel path.
package ltc_pkg;

  localparam int unsigned ARGB_W = 32;
  localparam int unsigned WORD_W = 64;

  typedef logic [ARGB_W-1:0] argb_t;
  typedef logic [WORD_W-1:0] lattice_word_t;

  // Which half of the FIFO head word is currently presented on the output.
  typedef enum logic {
    HALF_LO = 1'b0,
    HALF_HI = 1'b1
  } half_e;

  function automatic argb_t pick_half(input lattice_word_t word, input half_e half);
    return (half == HALF_HI) ? word[WORD_W-1:ARGB_W] : word[ARGB_W-1:0];
  endfunction

endpackage

// File: rtl/ltcpix_fifo.sv
// DEPTH x 64-bit word FIFO with registered occupancy count and full/empty flags.
module ltcpix_fifo
  import ltc_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  lattice_word_t wr_data,
  input  logic          wr_en,
  input  logic          rd_en,
  output lattice_word_t rd_data,
  output logic          full,
  output logic          empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  lattice_word_t mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          push;
  logic          pop;

  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign push    = wr_en && !full;
  assign pop     = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  // Storage carries no reset; stale words are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end
    end
  end

endmodule

// File: rtl/ltcpix_stream.sv
// Serialises 64-bit lattice words into a raster ARGB pixel stream with sof/eol/frame_done.
// Optional macro LTCPIX_UNDERRUN_CNT_EN adds the 16-bit underrun_cnt output.
module ltcpix_stream
  import ltc_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned H_PIXELS = 256,
  parameter int unsigned V_LINES  = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ARGB_W-1:0] out_pixel,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sof,
  output logic              out_eol,
  output logic              frame_done
`ifdef LTCPIX_UNDERRUN_CNT_EN
  ,
  output logic [15:0]       underrun_cnt
`endif
);

  localparam int unsigned XW = (H_PIXELS > 1) ? $clog2(H_PIXELS) : 1;
  localparam int unsigned YW = (V_LINES > 1) ? $clog2(V_LINES) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(H_PIXELS - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_LINES - 1);

  lattice_word_t head;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          xfer;
  half_e         half;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic          at_line_end;
  logic          at_frame_end;
  logic          at_origin;

  ltcpix_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .wr_data(in_data),
    .wr_en  (push),
    .rd_en  (pop),
    .rd_data(head),
    .full   (full),
    .empty  (empty)
  );

  // Handshakes are forced low during reset so nothing transfers on the reset edge.
  assign in_ready  = !full && !rst;
  assign out_valid = !empty && !rst;
  assign push      = in_valid && in_ready;
  assign xfer      = out_valid && out_ready;
  assign pop       = xfer && (half == HALF_HI);

  assign at_line_end  = (x == X_LAST);
  assign at_frame_end = at_line_end && (y == Y_LAST);
  assign at_origin    = (x == '0) && (y == '0);

  assign out_pixel = pick_half(head, half);
  assign out_sof   = at_origin;
  assign out_eol   = at_line_end;

  always_ff @(posedge clk) begin
    if (rst) begin
      half       <= HALF_LO;
      x          <= '0;
      y          <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= xfer && at_frame_end;
      if (xfer) begin
        half <= (half == HALF_LO) ? HALF_HI : HALF_LO;
        if (at_line_end) begin
          x <= '0;
          y <= (y == Y_LAST) ? '0 : y + YW'(1);
        end else begin
          x <= x + XW'(1);
        end
      end
    end
  end

`ifdef LTCPIX_UNDERRUN_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      underrun_cnt <= '0;
    end else if (out_ready && !out_valid && !at_origin && (underrun_cnt != '1)) begin
      underrun_cnt <= underrun_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ltcpix_stream.sv
// Scoreboard bench for ltcpix_stream on a small 4x2 raster with a 4-word FIFO.
module tb_ltcpix_stream;
  import ltc_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned HP    = 4;
  localparam int unsigned VL    = 2;
  localparam int unsigned FRAME = HP * VL;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_pixel;
  logic        out_valid;
  logic        out_ready;
  logic        out_sof;
  logic        out_eol;
  logic        frame_done;
`ifdef LTCPIX_UNDERRUN_CNT_EN
  logic [15:0] underrun_cnt;
`endif

  ltcpix_stream #(
    .DEPTH   (DEPTH),
    .H_PIXELS(HP),
    .V_LINES (VL)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_pixel (out_pixel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sof   (out_sof),
    .out_eol   (out_eol),
    .frame_done(frame_done)
`ifdef LTCPIX_UNDERRUN_CNT_EN
    ,
    .underrun_cnt(underrun_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pix;
    bit          sof;
    bit          eol;
    bit          last;
  } exp_t;

  exp_t        sb[$];
  int unsigned pos;
  int unsigned xfers;
  bit          fd_pend;
  int          checks;
  int          errors;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: every accepted word yields two pixels at successive raster positions.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      sb.delete();
      pos = 0;
    end else if (in_valid && in_ready) begin
      for (int h = 0; h < 2; h++) begin
        e.pix  = (h == 1) ? in_data[63:32] : in_data[31:0];
        e.sof  = (pos == 0);
        e.eol  = ((pos % HP) == HP - 1);
        e.last = (pos == FRAME - 1);
        sb.push_back(e);
        pos = (pos + 1) % FRAME;
      end
    end
  end

  // Monitor: compare every output transfer and the frame_done pulse timing.
  always @(negedge clk) begin
    exp_t e;
    check("frame_done", {63'd0, frame_done}, {63'd0, fd_pend});
    fd_pend = 1'b0;
    if (!rst && out_valid && out_ready) begin
      xfers++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pixel actual=%0h required=none at %0t", out_pixel, $time);
      end else begin
        e = sb.pop_front();
        check("pixel", {32'd0, out_pixel}, {32'd0, e.pix});
        check("sof", {63'd0, out_sof}, {63'd0, e.sof});
        check("eol", {63'd0, out_eol}, {63'd0, e.eol});
        fd_pend = e.last;
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int unsigned n);
    rst      = 1'b1;
    in_valid = 1'b0;
    for (int unsigned i = 0; i < n; i++) begin
      cycle();
      check("rst_in_ready", {63'd0, in_ready}, 64'd0);
      check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    end
    rst = 1'b0;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 200 && (out_valid || sb.size() != 0); i++) cycle();
    check("drain_out_valid", {63'd0, out_valid}, 64'd0);
    check("drain_queue", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    int unsigned base;
    int unsigned acc;
    checks    = 0;
    errors    = 0;
    xfers     = 0;
    fd_pend   = 1'b0;
    pos       = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    #1;
    do_reset(3);

    // Single word: low pixel one cycle after the push, then high pixel, then empty.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 64'h2222_2222_1111_1111;
    cycle();
    in_valid = 1'b0;
    check("first_valid", {63'd0, out_valid}, 64'd1);
    check("first_pixel", {32'd0, out_pixel}, 64'h1111_1111);
    check("first_sof", {63'd0, out_sof}, 64'd1);
    cycle();
    check("second_pixel", {32'd0, out_pixel}, 64'h2222_2222);
    cycle();
    check("after_valid", {63'd0, out_valid}, 64'd0);

    // Fill to full with the sink stalled; the fifth attempt must be refused.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_data = {$urandom, $urandom};
      cycle();
    end
    in_valid = 1'b0;
    check("full_in_ready", {63'd0, in_ready}, 64'd0);
    check("full_out_valid", {63'd0, out_valid}, 64'd1);
    drain();

    // Sink toggling every cycle while two words stream through.
    acc = 0;
    for (int i = 0; i < 24; i++) begin
      out_ready = (i % 2) == 0;
      in_valid  = (acc < 2);
      in_data   = {$urandom, $urandom};
      if (in_valid && in_ready) acc++;
      cycle();
    end
    in_valid = 1'b0;
    drain();

    // Random traffic across several frames.
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      in_data   = {$urandom, $urandom};
      cycle();
    end
    drain();

    // Reset after pixel 5 of a frame, then the next word must start a fresh frame.
    do_reset(1);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = {$urandom, $urandom};
      cycle();
    end
    in_valid  = 1'b0;
    base      = xfers;
    out_ready = 1'b1;
    for (int i = 0; i < 50 && xfers < base + 6; i++) cycle();
    check("mid_frame_xfers", 64'(xfers - base), 64'd6);
    do_reset(1);
    cycle();
    check("post_rst_empty", {63'd0, out_valid}, 64'd0);
    in_valid = 1'b1;
    in_data  = {$urandom, $urandom};
    cycle();
    in_valid = 1'b0;
    check("post_rst_sof", {63'd0, out_sof}, 64'd1);
    drain();

`ifdef LTCPIX_UNDERRUN_CNT_EN
    // Three starved cycles with the raster at x=2 of line 0.
    do_reset(1);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = {$urandom, $urandom};
    cycle();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (2) cycle();
    repeat (3) cycle();
    out_ready = 1'b0;
    cycle();
    check("underrun_cnt", {48'd0, underrun_cnt}, 64'd3);
    drain();
`endif

    // More random traffic with a final drain.
    for (int i = 0; i < 300; i++) begin
      in_valid  = ($urandom % 2) != 0;
      out_ready = ($urandom % 4) != 0;
      in_data   = {$urandom, $urandom};
      cycle();
    end
    drain();
    repeat (3) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
